// File: rtl/key_pkg.sv
// Shared constants and helpers for the key debouncer family.
// The long-press feature is built only when KEY_LONG_PRESS_EN is defined.
package key_pkg;

  localparam int unsigned BOARD_CLK_HZ          = 50_000_000;
  localparam int unsigned BOARD_DEBOUNCE_CYCLES = BOARD_CLK_HZ / 50;
  localparam int unsigned BOARD_LONG_CYCLES     = BOARD_CLK_HZ;
  localparam int unsigned BOARD_CNT_W           = 20;
  localparam int unsigned BOARD_LONG_W          = 26;

  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_PRESS   = 2'd1,
    EV_RELEASE = 2'd2
  } key_evt_e;

  // Pin level of a key that is not pressed.
  function automatic logic idle_level(input int unsigned active_low);
    return (active_low != 0);
  endfunction

  // True when max_val is representable in width bits.
  function automatic bit width_fits(input int unsigned max_val,
                                    input int unsigned width);
    return (max_val == 0) || ($clog2(max_val + 1) <= width);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, stable-time filter, edge pulses and,
// with KEY_LONG_PRESS_EN defined, a one-shot long-press detector.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = BOARD_CNT_W,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = BOARD_LONG_CYCLES,
  parameter int unsigned LONG_W          = BOARD_LONG_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long,
  output logic key_press_next
);

  localparam logic             IDLE_PIN = idle_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
    $error("key_debounce_chan: DEBOUNCE_CYCLES must be >= 1");
  end
  if (!width_fits(DEBOUNCE_CYCLES - 1, CNT_W)) begin : g_bad_cnt_w
    $error("key_debounce_chan: CNT_W too narrow for DEBOUNCE_CYCLES");
  end

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             norm;
  key_evt_e         evt;

  always_comb begin
    s1_d      = key_in;
    s2_d      = s1_q;
    norm      = s2_q ^ IDLE_PIN;
    state_d   = state_q;
    cnt_d     = cnt_q;
    evt       = EV_NONE;
    if (norm == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = norm;
      cnt_d   = '0;
      evt     = norm ? EV_PRESS : EV_RELEASE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d   = (evt == EV_PRESS);
    release_d = (evt == EV_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= IDLE_PIN;
      s2_q      <= IDLE_PIN;
      state_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_state      = state_q;
  assign key_press      = press_q;
  assign key_release    = release_q;
  assign key_press_next = press_d;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] HCNT_MAX = LONG_W'(LONG_CYCLES - 1);

  if (LONG_CYCLES < 1) begin : g_bad_long
    $error("key_debounce_chan: LONG_CYCLES must be >= 1");
  end
  if (!width_fits(LONG_CYCLES - 1, LONG_W)) begin : g_bad_long_w
    $error("key_debounce_chan: LONG_W too narrow for LONG_CYCLES");
  end

  logic [LONG_W-1:0] hcnt_q, hcnt_d;
  logic              done_q, done_d;
  logic              long_q, long_d;

  // hcnt saturates at LONG_CYCLES-1; done_q keeps the pulse to one per press,
  // and a release accepted on the same edge suppresses it.
  always_comb begin
    hcnt_d = hcnt_q;
    done_d = done_q;
    long_d = 1'b0;
    if (!state_q) begin
      hcnt_d = '0;
      done_d = 1'b0;
    end else if (hcnt_q != HCNT_MAX) begin
      hcnt_d = hcnt_q + LONG_W'(1);
    end else if (!done_q && state_d) begin
      long_d = 1'b1;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      done_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      done_q <= done_d;
      long_q <= long_d;
    end
  end

  assign key_long = long_q;
`else
  if (LONG_CYCLES < 1 || LONG_W < 1) begin : g_bad_long
    $error("key_debounce_chan: LONG_CYCLES and LONG_W must be >= 1");
  end

  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// NUM_KEYS independent debounced key channels plus a registered any_press.
// Define KEY_LONG_PRESS_EN to build the per-channel long-press detector.
module key_debounce_array
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = BOARD_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = BOARD_CNT_W,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned LONG_CYCLES     = BOARD_LONG_CYCLES,
  parameter int unsigned LONG_W          = BOARD_LONG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                any_press
);

  if (NUM_KEYS < 1) begin : g_bad_num
    $error("key_debounce_array: NUM_KEYS must be >= 1");
  end

  logic [NUM_KEYS-1:0] press_next;
  logic                any_press_q, any_press_d;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONG_CYCLES     (LONG_CYCLES),
      .LONG_W          (LONG_W)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .key_in         (key_in[i]),
      .key_state      (key_state[i]),
      .key_press      (key_press[i]),
      .key_release    (key_release[i]),
      .key_long       (key_long[i]),
      .key_press_next (press_next[i])
    );
  end

  // Reduced from the channels' next-state pulses so any_press lines up
  // with key_press instead of trailing it by a cycle.
  always_comb begin
    any_press_d = |press_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Parametrised multi-channel key debouncer, successor to the single-key debouncer. It synchronises NUM_KEYS raw mechanical key inputs and filters each one independently with a stable-time counter. Per channel it outputs a debounced level, single-cycle press/release pulses and an optional long-press pulse. It sits between the board key pins and the key/LED control logic.

## Interface
- NUM_KEYS, 4: number of independent key channels (≥1).
- DEBOUNCE_CYCLES, 1_000_000: cycles a new level must stay stable before it is accepted (≥1).
- CNT_W, 20: debounce counter width; requires DEBOUNCE_CYCLES-1 < 2**CNT_W (elaboration-time check).
- ACTIVE_LOW, 1: 1 = a pressed key drives the pin low; 0 = a pressed key drives it high.
- LONG_CYCLES, 50_000_000: cycles of debounced hold before a long-press pulse. Used only with KEY_LONG_PRESS_EN.
- LONG_W, 26: long-press counter width; requires LONG_CYCLES-1 < 2**LONG_W.

- clk  in  1  system clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous key pins.
- key_state  out  NUM_KEYS  debounced level, normalised: 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse when key_state goes 0→1.
- key_release  out  NUM_KEYS  one-cycle pulse when key_state goes 1→0.
- key_long  out  NUM_KEYS  one-cycle pulse after the long-press hold time; constant 0 without KEY_LONG_PRESS_EN.
- any_press  out  1  OR-reduction of key_press, registered in the same cycle as key_press.

## Operation
- Each channel has a 2-flop synchroniser: s1 <= key_in, s2 <= s1. Both reset to the idle pin level (ACTIVE_LOW ? 1 : 0).
- Normalised sample: n = s2 ^ ACTIVE_LOW.
- Debounce counter cnt, applied at each clock edge:
  - n == key_state: cnt <= 0.
  - n != key_state and cnt == DEBOUNCE_CYCLES-1: key_state <= n, cnt <= 0, and the matching press/release pulse is asserted for this one cycle.
  - Otherwise: cnt <= cnt+1.
- Any bounce back to the current key_state level clears cnt, so filtering restarts from zero.
- Each channel is fully independent. Simultaneous events on different channels all pulse in the same cycle.
- Long press (macro enabled): hold counter hcnt.
  - Clears while key_state == 0.
  - Increments while key_state == 1 until it reaches LONG_CYCLES-1.
  - key_long pulses once on the cycle hcnt reaches LONG_CYCLES-1, then hcnt saturates. There is exactly one pulse per press.
  - Release clears hcnt; a new press re-arms the detector.
- Reset values: key_state, key_press, key_release, key_long and any_press are 0; cnt and hcnt are 0.
- Reset mid-bounce discards all progress.
- A key held through reset is reported as a fresh press (key_press pulse) once the debounce period elapses after reset.
- Reset never produces a key_release pulse.

## Timing
- A raw change first sampled by s1 at edge k appears on key_state at edge k+1+DEBOUNCE_CYCLES, provided it stays stable.
- key_press and key_release are high for exactly the one cycle following the edge on which key_state changes.
- key_long asserts LONG_CYCLES edges after the key_state 0→1 edge.
- Pulses never overlap on one channel. key_press and key_release on the same channel are at least DEBOUNCE_CYCLES cycles apart.
- DEBOUNCE_CYCLES = 1: the level is accepted on the first cycle n differs, giving 2-cycle latency from s1.

## Configuration
- KEY_LONG_PRESS_EN defined: hcnt is instantiated per channel and key_long behaves as specified above.
- KEY_LONG_PRESS_EN undefined: no hcnt logic is built; key_long is tied to 0 and LONG_CYCLES/LONG_W are ignored. The port list is identical in both builds.

## Structure
- Shared package key_pkg holds:
  - the default-constant helper for the idle pin level;
  - the clog2-based width-check function used by the elaboration asserts;
  - localparams for board defaults (50 MHz: 20 ms debounce, 1 s long press).
- Sub-module key_debounce_chan: one channel containing the synchroniser, cnt, key_state, pulses and optional hcnt. The top level is a generate loop plus any_press.

## Test plan
- Clean press, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1: key_in[0] 1→0 sampled at edge 0 → key_state[0]=1 after edge 5; key_press[0] high one cycle; any_press high the same cycle.
- Bounce, DEBOUNCE_CYCLES=4: key_in[1] toggles 0,1,0 at 2-cycle spacing, then holds 0 → key_state[1] rises exactly 5 edges after the last toggle is sampled; a single key_press[1] pulse.
- Glitch shorter than the debounce time: key_in[2] low for 3 cycles with DEBOUNCE_CYCLES=4 → key_state[2] stays 0; no pulses.
- Simultaneous channels plus release: keys 0 and 3 pressed on the same edge, then released → press pulses on the same cycle for both, later release pulses on the same cycle for both.
- Long press, macro on, LONG_CYCLES=10: hold key 0 → key_long[0] pulses once, 10 edges after key_state rises, with no repeat. Macro off → key_long stays 0.
- Reset mid-operation: assert rst at cnt=2 while key 0 is held, release rst → all outputs 0 during reset; key_press[0] fires 5 edges after the first post-reset s1 sample; no key_release pulse.
